// File: rtl/lattice_readout_pkg.sv
// lattice_readout_pkg
// Shared definitions for the lattice readout slice: default geometry of the
// lattice direction BRAM and the readout FSM state encoding.
// No ports (package).
package lattice_readout_pkg;

  // Default lattice geometry used when the block is instantiated without
  // overrides.
  localparam int ADDRESS_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int WIDTH_DEF         = 4;
  localparam int DEPTH_DEF         = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lattice_readout_if.sv
// lattice_readout_if
// AXI4-Stream style bundle carrying lattice words from the readout block
// to the DMA/host side.
//   tdata  : stream word
//   tvalid : word valid (master drives)
//   tready : sink ready (slave drives)
//   tlast  : row end or frame end marker
//   tuser  : start-of-frame marker
interface lattice_readout_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/lattice_readout_fifo.sv
// readout_fifo
// Small synchronous show-ahead FIFO holding captured BRAM words together
// with their tlast/tuser tags. The head entry is visible on dout whenever
// empty is low.
//   clk, rst : clock, synchronous active-low reset (flushes the FIFO)
//   push/din : write one entry (accepted when not full, or full with pop)
//   pop      : consume the head entry (ignored when empty)
//   dout     : head entry
//   full, empty, count : occupancy status
module readout_fifo #(
  parameter int WIDTH       = 18,
  parameter int DEPTH       = 3,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == COUNT_WIDTH'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
    end
  end

endmodule

// File: rtl/lattice_readout.sv
// lattice_readout
// Sweeps DEPTH cells of a lattice direction BRAM starting at frame_base and
// streams each word out over AXI4-Stream, tagging row ends on tlast and the
// first word of the frame on tuser. Read-only towards the BRAM.
//   clk, rst     : clock, synchronous active-low reset
//   start        : one-cycle frame request (ignored while busy)
//   frame_base   : first BRAM address, sampled with start
//   busy, done   : readout in progress / one-cycle completion pulse
//   ram_addr     : registered BRAM read address
//   ram_en       : registered BRAM read strobe
//   ram_data_out : BRAM read data, valid READ_LATENCY cycles after ram_en
//   m_axis       : stream master (tdata/tvalid/tready/tlast/tuser)
module lattice_readout
  import lattice_readout_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int WIDTH         = WIDTH_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int READ_LATENCY  = 1,
  parameter bit ROW_LAST      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] frame_base,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_en,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  lattice_readout_if.master        m_axis
);

  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W      = $clog2(DEPTH + 1);
  localparam int COL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ENTRY_W    = DATA_WIDTH + 2;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]         issue_idx;
  logic [IDX_W-1:0]         cap_idx;
  logic [COL_W-1:0]         cap_col;
  logic [CNT_W-1:0]         in_flight;
  logic [READ_LATENCY-1:0]  rd_pipe;
  logic                     issue;
  logic                     credit_ok;
  logic [CNT_W:0]           occupancy;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic                     cap_last;
  logic                     cap_user;
  logic [ENTRY_W-1:0]       fifo_din;
  logic [ENTRY_W-1:0]       fifo_dout;

  assign pop  = !fifo_empty && m_axis.tready;
  assign push = rd_pipe[READ_LATENCY-1];

  // Every issued read owns a FIFO slot until it leaves on the stream. A beat
  // handshaking this cycle hands its slot back immediately, which is what
  // keeps a FIFO of READ_LATENCY+2 entries running at one beat per cycle.
  assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight} - {{CNT_W{1'b0}}, pop};
  assign credit_ok = !fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  // The first read goes out from the start cycle itself so ram_en appears
  // in the very next cycle.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          issue      = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (issue_idx == IDX_W'(DEPTH)) begin
          state_next = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        // Finish in the cycle the last word handshakes so done follows it
        // directly.
        if ((in_flight == '0) &&
            (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Words come back from the BRAM in issue order, so the tags can be worked
  // out at capture time and travel through the FIFO with the data.
  always_comb begin
    cap_user = (cap_idx == '0);
    if (ROW_LAST) begin
      cap_last = (cap_col == COL_W'(WIDTH - 1)) || (cap_idx == IDX_W'(DEPTH - 1));
    end else begin
      cap_last = (cap_idx == IDX_W'(DEPTH - 1));
    end
    fifo_din = {cap_user, cap_last, ram_data_out};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      base_q    <= '0;
      issue_idx <= '0;
      cap_idx   <= '0;
      cap_col   <= '0;
      in_flight <= '0;
      rd_pipe   <= '0;
    end else begin
      ram_en <= issue;
      if (issue) begin
        ram_addr <= (state == IDLE) ? frame_base
                                    : base_q + ADDRESS_WIDTH'(issue_idx);
      end

      if (state == IDLE && start) begin
        base_q    <= frame_base;
        issue_idx <= IDX_W'(1);
        cap_idx   <= '0;
        cap_col   <= '0;
      end else begin
        if (issue) begin
          issue_idx <= issue_idx + 1'b1;
        end
        if (push) begin
          cap_idx <= cap_idx + 1'b1;
          cap_col <= (cap_col == COL_W'(WIDTH - 1)) ? '0 : cap_col + 1'b1;
        end
      end

      // rd_pipe marks the cycle in which a read's data is on ram_data_out;
      // clearing it on reset drops any read still on its way back.
      rd_pipe[0] <= ram_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      in_flight <= in_flight + CNT_W'(issue) - CNT_W'(push);
    end
  end

  readout_fifo #(
    .WIDTH       (ENTRY_W),
    .DEPTH       (FIFO_DEPTH),
    .COUNT_WIDTH (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs are forced low while empty so nothing stale appears on the bus.
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_axis.tlast  = !fifo_empty && fifo_dout[DATA_WIDTH];
  assign m_axis.tuser  = !fifo_empty && fifo_dout[DATA_WIDTH+1];

endmodule
